// File: rtl/ok_btpipe_scheduler_pkg.sv
// ok_sched_pkg: shared state/read-kind encodings and BT block header layout
package ok_sched_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, XFER, DONE} state_t;
    typedef enum logic [1:0] {RD_NONE, RD_HDR, RD_DATA, RD_ZERO} rd_t;
    localparam logic [3:0] HDR_MAGIC = 4'hA;
    localparam int HDR_MAGIC_LSB = 12;
    localparam int HDR_SRC_LSB = 8;
    localparam int HDR_SEQ_LSB = 0;
    function automatic logic [15:0] mk_header(input logic [3:0] src, input logic [7:0] seq);
        logic [15:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 4] = HDR_MAGIC;
        h[HDR_SRC_LSB +: 4] = src;
        h[HDR_SEQ_LSB +: 8] = seq;
        return h;
    endfunction
endpackage

// File: rtl/ok_btpipe_scheduler_if.sv
// ok_btpipe_scheduler_if: okBTPipeOut endpoint handshake; master = host pipe, slave = scheduler
interface ok_btpipe_scheduler_if;
    logic        ep_read;
    logic        ep_blockstrobe;
    logic        ep_ready;
    logic [15:0] ep_datain;
    modport master(output ep_read, ep_blockstrobe, input ep_ready, ep_datain);
    modport slave(input ep_read, ep_blockstrobe, output ep_ready, ep_datain);
endinterface

// File: rtl/ok_btpipe_scheduler_rr_pick.sv
// ok_rr_pick: combinational round-robin pick of the first request at or after ptr
module ok_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   ptr,
    output logic [3:0]   grant,
    output logic         any_grant
);
    int idx;
    logic [N-1:0] r;
    always_comb begin
        grant = '0;
        any_grant = 1'b0;
        idx = 0;
        r = '0;
        // descending scan so the closest request to ptr is written last
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            r = req >> idx;
            if (r[0]) begin
                grant = 4'(idx);
                any_grant = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ok_btpipe_scheduler.sv
// ok_btpipe_scheduler: shares one okBTPipeOut between N_SRC FIFOs, one header word
// then BLOCK_WORDS-1 payload words per block, round-robin over eligible sources.
module ok_btpipe_scheduler
    import ok_sched_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int BLOCK_WORDS = 256,
    parameter int CNT_W = 10
) (
    input  logic                   ti_clk,
    input  logic                   rst,
    input  logic [N_SRC-1:0]       src_en,
    input  logic [N_SRC*CNT_W-1:0] src_count,
    output logic [N_SRC-1:0]       src_rd,
    input  logic [N_SRC*16-1:0]    src_data,
    ok_btpipe_scheduler_if.slave   ep,
    output logic [3:0]             cur_src,
    output logic [15:0]            blocks_done,
    output logic                   err,
    input  logic                   err_clr
);
    localparam int WCNT_W = $clog2(BLOCK_WORDS);
    localparam logic [WCNT_W-1:0] LAST = WCNT_W'(BLOCK_WORDS - 1);

    state_t state, state_nxt;
    rd_t rd_kind;
    logic [3:0] sel, rr_ptr, grant;
    logic any_elig, xfer_rd, bad;
    logic [7:0] seq;
    logic [WCNT_W-1:0] wcnt;
    logic [15:0] dout_q, fifo_word;
    logic [N_SRC-1:0] elig;

    for (genvar g = 0; g < N_SRC; g++) begin : g_elig
        assign elig[g] = src_en[g] && 32'(src_count[g*CNT_W +: CNT_W]) >= 32'(BLOCK_WORDS - 1);
    end

    ok_rr_pick #(.N(N_SRC)) u_pick (
        .req(elig),
        .ptr(rr_ptr),
        .grant(grant),
        .any_grant(any_elig)
    );

    always_ff @(posedge ti_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE  ? (any_elig ? ARMED : IDLE) :
                    state == ARMED ? (ep.ep_blockstrobe ? XFER : ARMED) :
                    state == XFER  ? ((ep.ep_read && wcnt == LAST) ? DONE : XFER) : IDLE;
    end

    always_comb begin
        xfer_rd = state == XFER && ep.ep_read;
        bad = (ep.ep_read && state != XFER) || (ep.ep_blockstrobe && state != ARMED);
        src_rd = (xfer_rd && wcnt != '0) ? (N_SRC'(1) << sel) : '0;
        ep.ep_ready = state == ARMED;
        fifo_word = 16'(src_data >> (16 * sel));
        // FIFO data lands one cycle after the pop, so the word is muxed live rather than registered
        ep.ep_datain = rd_kind == RD_HDR  ? mk_header(sel, seq) :
                       rd_kind == RD_DATA ? fifo_word :
                       rd_kind == RD_ZERO ? 16'h0000 : dout_q;
    end

    always_ff @(posedge ti_clk or posedge rst) begin
        if (rst) begin
            sel <= '0;
            rr_ptr <= '0;
            seq <= '0;
            wcnt <= '0;
            rd_kind <= RD_NONE;
            dout_q <= '0;
            blocks_done <= '0;
            err <= 1'b0;
        end else begin
            if (state == IDLE && any_elig) sel <= grant;
            if (state == ARMED && ep.ep_blockstrobe) wcnt <= '0;
            else if (xfer_rd) wcnt <= wcnt + 1'b1;
            rd_kind <= xfer_rd ? (wcnt == '0 ? RD_HDR : RD_DATA) : ep.ep_read ? RD_ZERO : RD_NONE;
            dout_q <= ep.ep_datain;
            if (state == DONE) begin
                seq <= seq + 8'd1;
                blocks_done <= blocks_done + 16'd1;
                rr_ptr <= (int'(sel) == N_SRC - 1) ? 4'd0 : sel + 4'd1;
            end
            err <= bad || (err && !err_clr);
        end
    end

    assign cur_src = sel;
endmodule

// File: tb/tb_ok_btpipe_scheduler.sv
// tb_ok_btpipe_scheduler: host-side pipe driver, FIFO models and a block-level scheduling model
module tb_ok_btpipe_scheduler;
    localparam int N = 4;
    localparam int BW = 256;
    localparam int CW = 10;

    logic ti_clk = 1'b0;
    logic rst = 1'b1;
    logic err_clr = 1'b0;
    logic [N-1:0] src_en = '0;
    logic [N-1:0] src_rd;
    logic [CW-1:0] cnt [N] = '{default: '0};
    logic [N*CW-1:0] src_count;
    logic [N*16-1:0] src_data;
    logic [15:0] fifo_q [N] = '{default: '0};
    int pops [N] = '{default: 0};
    logic [3:0] cur_src;
    logic [15:0] blocks_done;
    logic err;

    int n_chk = 0;
    int n_pass = 0;
    int m_ptr = 0;
    int m_seq = 0;
    int m_blocks = 0;
    int gap_max = 0;

    ok_btpipe_scheduler_if ep();

    ok_btpipe_scheduler #(.N_SRC(N), .BLOCK_WORDS(BW), .CNT_W(CW)) dut (
        .ti_clk(ti_clk),
        .rst(rst),
        .src_en(src_en),
        .src_count(src_count),
        .src_rd(src_rd),
        .src_data(src_data),
        .ep(ep),
        .cur_src(cur_src),
        .blocks_done(blocks_done),
        .err(err),
        .err_clr(err_clr)
    );

    always #5 ti_clk = ~ti_clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign src_count[g*CW +: CW] = cnt[g];
        assign src_data[g*16 +: 16] = fifo_q[g];
    end

    function automatic logic [15:0] word(input int s, input int p);
        return {4'(s), 12'(p * 5 + 3)};
    endfunction

    // standard FIFO: the popped word appears on the output the cycle after the pop
    always @(posedge ti_clk) begin
        for (int i = 0; i < N; i++) begin
            if (src_rd[i]) begin
                fifo_q[i] <= word(i, pops[i]);
                pops[i] <= pops[i] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (src_en[i] && int'(cnt[i]) >= BW - 1) return i;
        end
        return -1;
    endfunction

    function automatic int pop_total();
        int t;
        t = 0;
        for (int i = 0; i < N; i++) t += pops[i];
        return t;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ep.ep_read = 1'b0;
        ep.ep_blockstrobe = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge ti_clk);
        rst = 1'b0;
        m_ptr = 0;
        m_seq = 0;
        m_blocks = 0;
    endtask

    // Waits for ep_ready, strobes, then performs n_reads reads (a full block when n_reads == BW)
    task automatic run_block(input int n_reads, output logic [15:0] hdr);
        int s, t, bad, p0, tot0, g;
        logic [15:0] last;
        logic [N-1:0] exp_rd;
        s = pick();
        hdr = '0;
        t = 0;
        while (!ep.ep_ready && t < 50) begin
            @(negedge ti_clk);
            t++;
        end
        check("ready", 32'(ep.ep_ready), 1);
        check("cur_src", 32'(cur_src), 32'(s));
        check("blocks_done", 32'(blocks_done), 32'(m_blocks));
        p0 = (s >= 0) ? pops[s] : 0;
        tot0 = pop_total();
        ep.ep_blockstrobe = 1'b1;
        @(negedge ti_clk);
        ep.ep_blockstrobe = 1'b0;
        check("ready_drop", 32'(ep.ep_ready), 0);
        bad = 0;
        last = ep.ep_datain;
        for (int w = 0; w < n_reads; w++) begin
            g = (gap_max > 0 && $urandom_range(3, 0) == 0) ? int'($urandom_range(gap_max, 1)) : 0;
            repeat (g) begin
                @(negedge ti_clk);
                if (ep.ep_datain !== last || src_rd !== '0) bad++;
            end
            ep.ep_read = 1'b1;
            exp_rd = (w == 0) ? '0 : (N'(1) << s);
            #1;
            if (src_rd !== exp_rd) bad++;
            @(negedge ti_clk);
            ep.ep_read = 1'b0;
            if (w == 0) hdr = ep.ep_datain;
            else if (ep.ep_datain !== word(s, p0 + w - 1)) bad++;
            last = ep.ep_datain;
        end
        check("data", 32'(bad), 0);
        if (n_reads == BW) begin
            check("header", 32'(hdr), 32'({4'hA, 4'(s), 8'(m_seq)}));
            check("pops", 32'(pops[s] - p0), 32'(BW - 1));
            check("pops_total", 32'(pop_total() - tot0), 32'(BW - 1));
            m_ptr = (s + 1) % N;
            m_seq = (m_seq + 1) % 256;
            m_blocks++;
        end
    endtask

    typedef struct {
        logic [3:0] en;
        int c0, c1, c2, c3;
        logic rdy;
        int src;
    } vec_t;

    initial begin
        vec_t vecs [8];
        logic [15:0] h;
        int rr_exp [4];
        ep.ep_read = 1'b0;
        ep.ep_blockstrobe = 1'b0;
        vecs[0] = '{4'b0001, 300, 300, 300, 300, 1'b1, 0};
        vecs[1] = '{4'b0000, 300, 300, 300, 300, 1'b0, 0};
        vecs[2] = '{4'b0100, 300, 300, 254, 300, 1'b0, 0};
        vecs[3] = '{4'b0100, 300, 300, 255, 300, 1'b1, 2};
        vecs[4] = '{4'b1010, 300, 300, 300, 300, 1'b1, 1};
        vecs[5] = '{4'b1111, 10, 254, 255, 300, 1'b1, 2};
        vecs[6] = '{4'b1000, 0, 0, 0, 1023, 1'b1, 3};
        vecs[7] = '{4'b1110, 300, 100, 254, 255, 1'b1, 3};
        rr_exp = '{1, 3, 1, 3};

        do_reset();
        check("rst_ready", 32'(ep.ep_ready), 0);
        check("rst_datain", 32'(ep.ep_datain), 0);
        check("rst_err", 32'(err), 0);
        check("rst_blocks", 32'(blocks_done), 0);

        // eligibility table, fresh reset per vector so the pointer is 0
        for (int v = 0; v < 8; v++) begin
            do_reset();
            src_en = vecs[v].en;
            cnt[0] = CW'(vecs[v].c0);
            cnt[1] = CW'(vecs[v].c1);
            cnt[2] = CW'(vecs[v].c2);
            cnt[3] = CW'(vecs[v].c3);
            repeat (3) @(negedge ti_clk);
            check($sformatf("vec%0d_ready", v), 32'(ep.ep_ready), 32'(vecs[v].rdy));
            if (vecs[v].rdy) check($sformatf("vec%0d_src", v), 32'(cur_src), 32'(vecs[v].src));
        end

        // single source, one full block
        do_reset();
        src_en = 4'b0001;
        cnt = '{300, 300, 300, 300};
        run_block(BW, h);
        check("single_hdr", 32'(h), 32'h0000_A000);
        @(negedge ti_clk);
        check("single_blocks", 32'(blocks_done), 1);

        // round-robin between sources 1 and 3
        do_reset();
        src_en = 4'b1010;
        for (int b = 0; b < 4; b++) begin
            run_block(BW, h);
            check("rr_src", 32'(h[11:8]), 32'(rr_exp[b]));
            check("rr_seq", 32'(h[7:0]), 32'(b));
        end

        // threshold: one word short stays idle
        do_reset();
        src_en = 4'b0100;
        cnt = '{300, 300, 254, 300};
        repeat (10) @(negedge ti_clk);
        check("thr_below", 32'(ep.ep_ready), 0);
        cnt[2] = 255;
        repeat (2) @(negedge ti_clk);
        check("thr_at", 32'(ep.ep_ready), 1);

        // protocol error: read while idle
        do_reset();
        src_en = 4'b0001;
        cnt = '{300, 300, 300, 300};
        run_block(BW, h);
        src_en = 4'b0000;
        @(negedge ti_clk);
        check("err_pre", 32'(err), 0);
        check("hold_idle", 32'(ep.ep_datain), 32'(word(0, pops[0] - 1)));
        ep.ep_read = 1'b1;
        #1;
        check("err_no_rd", 32'(src_rd), 0);
        @(negedge ti_clk);
        ep.ep_read = 1'b0;
        check("err_set", 32'(err), 1);
        check("err_datain", 32'(ep.ep_datain), 0);
        err_clr = 1'b1;
        ep.ep_read = 1'b1;
        @(negedge ti_clk);
        ep.ep_read = 1'b0;
        check("err_clr_vs_new", 32'(err), 1);
        @(negedge ti_clk);
        err_clr = 1'b0;
        check("err_cleared", 32'(err), 0);

        // reset in the middle of a block
        do_reset();
        src_en = 4'b0011;
        run_block(BW, h);
        run_block(100, h);
        check("mid_src", 32'(cur_src), 1);
        rst = 1'b1;
        #1;
        check("mid_ready", 32'(ep.ep_ready), 0);
        check("mid_rd", 32'(src_rd), 0);
        check("mid_datain", 32'(ep.ep_datain), 0);
        check("mid_cur_src", 32'(cur_src), 0);
        check("mid_blocks", 32'(blocks_done), 0);
        check("mid_err", 32'(err), 0);
        @(negedge ti_clk);
        rst = 1'b0;
        m_ptr = 0;
        m_seq = 0;
        m_blocks = 0;
        run_block(BW, h);
        check("mid_after_hdr", 32'(h), 32'h0000_A000);

        // randomized sources, counts and read gaps against the model
        do_reset();
        gap_max = 3;
        for (int b = 0; b < 8; b++) begin
            int tries;
            tries = 0;
            do begin
                src_en = 4'($urandom_range(15, 1));
                for (int i = 0; i < N; i++) cnt[i] = CW'($urandom_range(300, 240));
                tries++;
            end while (pick() < 0 && tries < 100);
            if (pick() < 0) begin
                src_en = 4'b0001;
                cnt[0] = 300;
            end
            run_block(BW, h);
        end
        gap_max = 0;

        // sequence wrap over 257 blocks
        do_reset();
        src_en = 4'b0001;
        cnt = '{300, 300, 300, 300};
        for (int b = 0; b < 257; b++) run_block(BW, h);
        check("wrap_hdr", 32'(h), 32'h0000_A000);
        @(negedge ti_clk);
        check("wrap_blocks", 32'(blocks_done), 257);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ok_btpipe_scheduler.md
Name: ok_btpipe_scheduler

Overview:
Shares one okBTPipeOut endpoint between N_SRC source FIFOs in the host-interface clock domain. Round-robin selects a source holding at least one block of data and asserts ep_ready. It then serves the host's block transfer: one header word followed by payload words popped from the selected FIFO. Provides wire-out status and a sticky protocol-error flag.

Parameters:
N_SRC, 4, number of source FIFOs (1..16)
BLOCK_WORDS, 256, 16-bit words per BT block including header (>=2; must match host block length)
CNT_W, 10, width of each src_count field

Ports:
ti_clk  in  1  host-interface clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
src_en  in  N_SRC  per-source enable (from okWireIn)
src_count  in  N_SRC*CNT_W  words available per FIFO; field i at [i*CNT_W +: CNT_W]
src_rd  out  N_SRC  FIFO pop; standard FIFOs, data valid 1 cycle after pop
src_data  in  N_SRC*16  FIFO read data; field i at [i*16 +: 16]
ep_read  in  1  from okBTPipeOut
ep_blockstrobe  in  1  from okBTPipeOut
ep_ready  out  1  to okBTPipeOut
ep_datain  out  16  to okBTPipeOut
cur_src  out  4  selected source index
blocks_done  out  16  completed blocks, wraps
err  out  1  sticky protocol error
err_clr  in  1  clears err

Behaviour:
- Reset: state IDLE; ep_ready=0, src_rd=0, ep_datain=0, cur_src=0, blocks_done=0, err=0; rr_ptr=0; seq=0.
- Eligible(i) = src_en[i] && src_count[i] >= BLOCK_WORDS-1.
- IDLE: if any source is eligible, sel <= first eligible at or after rr_ptr (cyclic) and go to ARMED. ep_ready=1 is registered and visible from the first ARMED cycle. cur_src <= sel.
- ARMED: hold ep_ready=1 until ep_blockstrobe, then go to XFER with wcnt=0. ep_ready drops the cycle after the strobe. Selection is locked: src_en and src_count changes are ignored until the next IDLE.
- XFER:
  - Each ep_read increments wcnt.
  - Read at wcnt==0 returns the header: src_rd is not pulsed.
  - Reads at wcnt>=1 drive src_rd[sel]=ep_read combinationally, same cycle.
  - The cycle after any read, ep_datain = header if the registered header phase is set, else src_data[sel].
  - Header = {4'hA, sel[3:0], seq[7:0]}.
  - The read at wcnt==BLOCK_WORDS-1 moves to DONE.
- DONE, 1 cycle: last data word presented. Then seq+1 (8-bit wrap), blocks_done+1, rr_ptr <= sel+1 (mod N_SRC), back to IDLE.
- ep_datain holds its last value when no read occurred in the prior cycle. It is 0 after reset.
- Errors set err, which holds until an err_clr pulse:
  - ep_read in IDLE, ARMED or DONE: src_rd stays 0, ep_datain=0 next cycle.
  - ep_blockstrobe outside ARMED: ignored.
  - err_clr and a new error in the same cycle: err stays 1.
- Back-to-back reads every cycle are supported; gaps in ep_read are tolerated.
- rst mid-block: immediate return to reset state. The partial block is lost and FIFO words already popped are discarded.
- N_SRC=1: arbitration degenerates to the enable+count check.

Decomposition:
- Package ok_sched_pkg: HDR_MAGIC=4'hA; state encoding IDLE/ARMED/XFER/DONE; header field offsets.
- Sub-module ok_rr_pick (parameter N): inputs req[N] and ptr; outputs grant index and any_grant. Purely combinational priority rotate.

Test Plan:
- Single source: src 0 enabled with count=300, host reads a 256-word block -> ep_ready before strobe; word0=16'hA000; words 1..255 equal FIFO data in order; exactly 255 src_rd pulses; blocks_done=1.
- Round-robin: sources 1 and 3 eligible, four blocks -> header src fields 1,3,1,3; seq 0,1,2,3.
- Threshold: src 2 enabled with count=254 -> ep_ready stays 0. Count raised to 255 -> ep_ready=1 within 2 cycles.
- Protocol error: ep_read pulse in IDLE -> err=1, no src_rd, ep_datain=0. err_clr -> err=0.
- Seq wrap: 257 blocks from src 0 -> the 257th header is 16'hA000 and blocks_done=257.
- Reset mid-block: rst asserted at wcnt=100 -> all outputs at reset values same cycle. After release, the next block has header seq=0 and src=0.
